abuf_rd_ctrl: RTL and testbench



---
 rtl/abuf_rd_ctrl_pkg.sv | 40 ++++
 rtl/abuf_rd_fifo.sv | 53 +++++
 rtl/abuf_rd_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_abuf_rd_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/abuf_rd_ctrl_pkg.sv
// Shared parameters, width helper and beat/tag types for the accumulation-buffer read path.
package abuf_rd_ctrl_pkg;

    localparam int RES_W     = 16;
    localparam int BATCH     = 2;
    localparam int PE_NUM    = 32;
    localparam int GRP_NUM   = PE_NUM / 4;
    localparam int BUF_DEPTH = 256;

    // Bits needed to index n items; never less than one bit.
    function automatic int bw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int GRP_W  = bw(GRP_NUM);
    localparam int ADDR_W = bw(BUF_DEPTH);
    localparam int DATA_W = 4 * BATCH * RES_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    typedef struct packed {
        logic [GRP_W-1:0]  grp;
        logic [ADDR_W-1:0] addr;
        logic              last;
    } abuf_tag_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [GRP_W-1:0]  grp;
        logic [ADDR_W-1:0] addr;
        logic              last;
    } abuf_beat_t;

    localparam int BEAT_W = $bits(abuf_beat_t);

endpackage

// File: rtl/abuf_rd_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on rd_data_o whenever not empty.
module abuf_rd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             wr_fire_s;
    logic             rd_fire_s;

    assign empty_o   = (count_q == CNT_W'(0));
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    // Overflow/underflow are refused rather than corrupting state.
    assign wr_fire_s = wr_en_i && (count_q != CNT_W'(DEPTH));
    assign rd_fire_s = rd_en_i && !empty_o;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_fire_s) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : wr_ptr_q + PTR_W'(1);
            end
            if (rd_fire_s) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(wr_fire_s) - CNT_W'(rd_fire_s);
        end
    end

endmodule

// File: rtl/abuf_rd_ctrl.sv
// Sweeps all PE groups/addresses of the accum buffers and streams results out via a skid FIFO.
// Optional stall counter output enabled by defining ABUF_RD_STALL_CNT_EN.
module abuf_rd_ctrl
    import abuf_rd_ctrl_pkg::*;
#(
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [GRP_W-1:0]  grp_last,
    input  logic [ADDR_W-1:0] addr_last,
    output logic              busy,
    output logic              done,
    output logic [GRP_W-1:0]  rd_sel,
    output logic [ADDR_W-1:0] abuf_rd_addr,
    input  logic [DATA_W-1:0] abuf_rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic [GRP_W-1:0]  out_grp,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              out_valid,
`ifdef ABUF_RD_STALL_CNT_EN
    output logic [31:0]       stall_cnt,
`endif
    input  logic              out_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    rd_state_e         state_q, state_d;
    logic [GRP_W-1:0]  grp_ctr_q, grp_ctr_d;
    logic [ADDR_W-1:0] addr_ctr_q, addr_ctr_d;
    logic [GRP_W-1:0]  grp_last_q, grp_last_d;
    logic [ADDR_W-1:0] addr_last_q, addr_last_d;
    logic              done_q, done_d;
    logic [RD_LAT-1:0] pipe_vld_q;
    abuf_tag_t         pipe_tag_q [RD_LAT];
    logic              issue_s;
    abuf_tag_t         issue_tag_s;
    logic              is_last_s;
    logic              issue_ok_s;
    abuf_beat_t        fifo_wr_s;
    abuf_beat_t        fifo_head_s;
    logic              fifo_empty_s;
    logic [CNT_W-1:0]  fifo_cnt_s;
    logic              pop_s;

    // The counters are the read address: they hold between issues and step right after one.
    assign rd_sel       = grp_ctr_q;
    assign abuf_rd_addr = addr_ctr_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;

    // Every read in the pipe already owns a FIFO slot, so the FIFO cannot overflow.
    assign issue_ok_s = ($countones(pipe_vld_q) + int'(fifo_cnt_s)) < FIFO_DEPTH;
    assign is_last_s  = (grp_ctr_q == grp_last_q) && (addr_ctr_q == addr_last_q);

    assign fifo_wr_s = '{data: abuf_rd_data,
                         grp:  pipe_tag_q[RD_LAT-1].grp,
                         addr: pipe_tag_q[RD_LAT-1].addr,
                         last: pipe_tag_q[RD_LAT-1].last};

    assign out_valid = !fifo_empty_s;
    assign out_data  = fifo_head_s.data;
    assign out_grp   = fifo_head_s.grp;
    assign out_addr  = fifo_head_s.addr;
    assign out_last  = fifo_head_s.last;
    assign pop_s     = out_valid && out_ready;

    // Sweep sequencing: address is the inner loop, group the outer loop.
    always_comb begin
        state_d     = state_q;
        grp_ctr_d   = grp_ctr_q;
        addr_ctr_d  = addr_ctr_q;
        grp_last_d  = grp_last_q;
        addr_last_d = addr_last_q;
        done_d      = 1'b0;
        issue_s     = 1'b0;
        issue_tag_s = '0;
        case (state_q)
            IDLE: begin
                if (start && !done_q) begin
                    grp_last_d  = grp_last;
                    addr_last_d = addr_last;
                    grp_ctr_d   = '0;
                    addr_ctr_d  = '0;
                    state_d     = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (issue_ok_s) begin
                    issue_s     = 1'b1;
                    issue_tag_s = '{grp: grp_ctr_q, addr: addr_ctr_q, last: is_last_s};
                    if (is_last_s) begin
                        state_d = DRAIN;
                    end else if (addr_ctr_q == addr_last_q) begin
                        addr_ctr_d = '0;
                        grp_ctr_d  = grp_ctr_q + GRP_W'(1);
                    end else begin
                        addr_ctr_d = addr_ctr_q + ADDR_W'(1);
                    end
                end else begin
                    state_d = ISSUE;
                end
            end
            DRAIN: begin
                if (pop_s && fifo_head_s.last && (pipe_vld_q == '0)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and the read-latency tag pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grp_ctr_q   <= '0;
            addr_ctr_q  <= '0;
            grp_last_q  <= '0;
            addr_last_q <= '0;
            done_q      <= 1'b0;
            pipe_vld_q  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_tag_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            grp_ctr_q     <= grp_ctr_d;
            addr_ctr_q    <= addr_ctr_d;
            grp_last_q    <= grp_last_d;
            addr_last_q   <= addr_last_d;
            done_q        <= done_d;
            pipe_vld_q[0] <= issue_s;
            pipe_tag_q[0] <= issue_tag_s;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_tag_q[i] <= pipe_tag_q[i-1];
            end
        end
    end

    abuf_rd_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (pipe_vld_q[RD_LAT-1]),
        .wr_data_i (fifo_wr_s),
        .rd_en_i   (pop_s),
        .rd_data_o (fifo_head_s),
        .empty_o   (fifo_empty_s),
        .count_o   (fifo_cnt_s)
    );

`ifdef ABUF_RD_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    assign stall_cnt = stall_cnt_q;

    // Backpressure cycles seen during the current sweep, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
        end else if ((state_q == IDLE) && start && !done_q) begin
            stall_cnt_q <= 32'd0;
        end else if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_abuf_rd_ctrl.sv
// Scoreboard bench for abuf_rd_ctrl: an array model returns f(grp,addr) two cycles after the address.
module tb_abuf_rd_ctrl;
    import abuf_rd_ctrl_pkg::*;

    logic              clk;
    logic              rst;
    logic              start;
    logic [GRP_W-1:0]  grp_last;
    logic [ADDR_W-1:0] addr_last;
    logic              busy;
    logic              done;
    logic [GRP_W-1:0]  rd_sel;
    logic [ADDR_W-1:0] abuf_rd_addr;
    logic [DATA_W-1:0] abuf_rd_data;
    logic [DATA_W-1:0] out_data;
    logic [GRP_W-1:0]  out_grp;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
`ifdef ABUF_RD_STALL_CNT_EN
    logic [31:0]       stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    abuf_beat_t exp_q[$];
    logic [DATA_W-1:0] arr_d1, arr_d2;

    abuf_rd_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .grp_last     (grp_last),
        .addr_last    (addr_last),
        .busy         (busy),
        .done         (done),
        .rd_sel       (rd_sel),
        .abuf_rd_addr (abuf_rd_addr),
        .abuf_rd_data (abuf_rd_data),
        .out_data     (out_data),
        .out_grp      (out_grp),
        .out_addr     (out_addr),
        .out_last     (out_last),
        .out_valid    (out_valid),
`ifdef ABUF_RD_STALL_CNT_EN
        .stall_cnt    (stall_cnt),
`endif
        .out_ready    (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] arr_word(input int g, input int a);
        logic [15:0] w;
        w = {5'h15, 3'(g), 8'(a)};
        return {w, ~w, w ^ 16'hA5A5, w + 16'h1234, w, ~w, w ^ 16'h5A5A, w - 16'h0101};
    endfunction

    // Array model: PE buffer read register followed by the array output register.
    always @(posedge clk) begin
        arr_d1 <= arr_word(int'(rd_sel), int'(abuf_rd_addr));
        arr_d2 <= arr_d1;
    end
    assign abuf_rd_data = arr_d2;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ctl"}, {busy, done, rd_sel, abuf_rd_addr, out_valid, out_last, out_grp, out_addr}, 160'd0);
        chk({tag, "_data"}, out_data, 160'd0);
    endtask

    function automatic bit ready_at(input int mode, input int k);
        case (mode)
            1:       return (k % 2) == 0;
            2:       return !((k >= 6) && (k < 26));
            default: return 1'b1;
        endcase
    endfunction

    task automatic run_sweep(input int gl, input int al, input int mode, input bit pulse, input bit do_rst);
        int n;
        int first_k, done_k, last_hs_k, busy_cnt, acc, rst_k;
        bit prev_stall, rst_checked;
        abuf_beat_t prev_beat, cur, exp_b;
        n = (gl + 1) * (al + 1);
        first_k = -1; done_k = -1; last_hs_k = -1; busy_cnt = 0; acc = 0; rst_k = -1;
        prev_stall = 1'b0; rst_checked = 1'b0; prev_beat = '0;
        exp_q.delete();
        for (int g = 0; g <= gl; g++) begin
            for (int a = 0; a <= al; a++) begin
                exp_q.push_back('{data: arr_word(g, a), grp: GRP_W'(g), addr: ADDR_W'(a),
                                  last: (g == gl) && (a == al)});
            end
        end
        @(posedge clk); #1;
        start = 1'b1; grp_last = GRP_W'(gl); addr_last = ADDR_W'(al); out_ready = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            start     = pulse && ((k == 5) || (k == n + 3));
            out_ready = ready_at(mode, k);
            rst       = (rst_k >= 0) && (k == rst_k + 1);
            @(negedge clk);
            if ((rst_k >= 0) && (k == rst_k + 2)) begin
                check_reset_vals("mid_rst");
                rst_checked = 1'b1;
                break;
            end
            cur = '{data: out_data, grp: out_grp, addr: out_addr, last: out_last};
            if (busy) busy_cnt++;
            if (out_valid && (first_k < 0)) first_k = k;
            if (prev_stall) begin
                chk("hold_beat", cur, prev_beat);
                chk("hold_valid", out_valid, 1'b1);
            end
            prev_stall = out_valid && !out_ready;
            prev_beat  = cur;
            if ((mode == 2) && (k == 25)) begin
                chk("credit", int'(rd_sel) * (al + 1) + int'(abuf_rd_addr), acc + 4);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 1'b1, 1'b0);
                end else begin
                    exp_b = exp_q.pop_front();
                    chk("beat", cur, exp_b);
                end
                acc++;
                if (out_last) last_hs_k = k;
                if (do_rst && (acc == 5)) rst_k = k;
            end
            if (done) begin
                done_k = k;
                break;
            end
        end
        start = 1'b0;
        rst   = 1'b0;
        if (do_rst) begin
            chk("rst_reached", rst_checked, 1'b1);
            chk("rst_no_done", done_k, -1);
            exp_q.delete();
        end else begin
            chk("done_seen", done_k >= 0, 1'b1);
            chk("done_after_last", done_k, last_hs_k + 1);
            chk("beat_count", acc, n);
            chk("sb_empty", exp_q.size(), 0);
            chk("busy_len", busy_cnt, done_k);
            if (mode == 0) begin
                chk("first_beat_lat", first_k, 3);
                chk("sweep_len", done_k, n + 3);
            end
            @(posedge clk); #1;
            @(negedge clk);
            chk("idle_after_done", {busy, out_valid, done}, 3'b000);
`ifdef ABUF_RD_STALL_CNT_EN
            if (mode == 2) chk("stall_cnt", stall_cnt, 32'd20);
            if (mode == 0) chk("stall_cnt0", stall_cnt, 32'd0);
`endif
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; grp_last = '0; addr_last = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        run_sweep(1, 3, 0, 1'b1, 1'b0);
        run_sweep(1, 3, 1, 1'b0, 1'b0);
        run_sweep(3, 7, 2, 1'b0, 1'b0);
        run_sweep(0, 0, 0, 1'b0, 1'b0);
        run_sweep(3, 7, 0, 1'b0, 1'b1);
        run_sweep(3, 7, 0, 1'b1, 1'b0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
